// File: rtl/fifo_rd_arb_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_arb_ctrl
//
// Read-side controller of the async FIFO, running entirely in the rclk domain.
// It owns the read pointer in binary and Gray form and derives the empty,
// almost-empty and level status from the synchronized Gray write pointer.
// It also shares the single FIFO read port among NUM_REQ consumers with a
// round-robin arbiter that allows bounded bursts.
//
// Parameters:
//   ptr_width  address bits; pointers carry one extra wrap bit, depth = 2**ptr_width
//   NUM_REQ    number of read requesters (2..8)
//   BURST_LEN  max consecutive grants to one requester while others wait (1..15)
//   AE_THRESH  almost-empty threshold in entries
//
// Ports:
//   rclk           read clock
//   r_rst_n        synchronous active-low reset
//   wptr_sync      Gray write pointer, already synchronized to rclk
//   req            per-requester pop request, held until granted
//   gnt            one-hot grant (combinational); a grant is a pop this cycle
//   rd_en          memory read enable (= |gnt)
//   raddr          memory read address (low bits of the binary read pointer)
//   rdata_valid    registered; memory data valid for the previous cycle's pop
//   rdata_id       registered; requester that owns the rdata_valid beat
//   rptr           registered Gray read pointer, to the read-to-write synchronizer
//   rempty         registered empty flag
//   ralmost_empty  registered; rlevel <= AE_THRESH
//   rlevel         registered occupancy seen from the read side, 0..depth
// -----------------------------------------------------------------------------
module fifo_rd_arb_ctrl #(
    parameter int ptr_width = 9,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4,
    parameter int AE_THRESH = 4
) (
    input  logic                       rclk,
    input  logic                       r_rst_n,
    input  logic [ptr_width:0]         wptr_sync,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rd_en,
    output logic [ptr_width-1:0]       raddr,
    output logic                       rdata_valid,
    output logic [$clog2(NUM_REQ)-1:0] rdata_id,
    output logic [ptr_width:0]         rptr,
    output logic                       rempty,
    output logic                       ralmost_empty,
    output logic [ptr_width:0]         rlevel
);

    localparam int PW  = ptr_width + 1;     // pointer width incl. wrap bit
    localparam int IDW = $clog2(NUM_REQ);   // requester index width
    localparam int CW  = 4;                 // burst counter, holds up to 15

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray-to-binary is a prefix XOR from the MSB down.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]  rbin_q;
    logic [PW-1:0]  rptr_q;
    logic           rempty_q;
    logic           ralmost_empty_q;
    logic [PW-1:0]  rlevel_q;
    logic           rdata_valid_q;
    logic [IDW-1:0] rdata_id_q;

    arb_state_e     state_q,     state_d;
    logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0] owner_q,     owner_d;
    logic [CW-1:0]  burst_cnt_q, burst_cnt_d;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           others_wait;
    logic           pop;
    logic [IDW-1:0] sel;

    logic [PW-1:0]  rbin_d;
    logic [PW-1:0]  rptr_d;
    logic [PW-1:0]  wbin;
    logic [PW-1:0]  level_d;
    logic           rempty_d;
    logic           ralmost_empty_d;

    // Round-robin search: first requester at or after rr_ptr_q, wrapping.
    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path can leave it holding a value (no latch).
    always_comb begin : rr_search
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Somebody other than the current burst owner is asking.
    assign others_wait = |(req & ~(NUM_REQ'(1) << owner_q));

    // Arbiter next-state and grant. Grants are suppressed while the FIFO is
    // empty and while reset is held, whatever the requests look like.
    always_comb begin : arb_next
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        pop         = 1'b0;
        sel         = owner_q;

        unique case (state_q)
            ST_ARB: begin
                if (found && !rempty_q && r_rst_n) begin
                    pop         = 1'b1;
                    sel         = winner;
                    owner_d     = winner;
                    burst_cnt_d = CW'(1);
                    // With BURST_LEN=1 every grant closes the turn at once;
                    // otherwise BURST decides next cycle whether the owner
                    // still wants data.
                    if (BURST_LEN > 1) begin
                        state_d = ST_BURST;
                    end else begin
                        rr_ptr_d = next_idx(winner);
                    end
                end
            end

            ST_BURST: begin
                if (!req[owner_q] || rempty_q) begin
                    // Owner is done or nothing left to read: hand the turn on.
                    state_d  = ST_ARB;
                    rr_ptr_d = next_idx(owner_q);
                end else if (r_rst_n) begin
                    pop = 1'b1;
                    sel = owner_q;
                    // Counter saturates: with nobody else waiting the burst
                    // may run past BURST_LEN, and the limit then applies as
                    // soon as a competitor appears.
                    if (int'(burst_cnt_q) < BURST_LEN) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                    if ((int'(burst_cnt_q) + 1 >= BURST_LEN) && others_wait) begin
                        state_d  = ST_ARB;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // Pointer arithmetic wraps naturally modulo 2**PW.
    assign rbin_d          = rbin_q + PW'(pop);
    assign rptr_d          = bin2gray(rbin_d);
    assign wbin            = gray2bin(wptr_sync);
    assign level_d         = wbin - rbin_d;
    assign rempty_d        = (rptr_d == wptr_sync);
    assign ralmost_empty_d = (level_d <= PW'(AE_THRESH));

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled on the rclk edge like any other input; every
    // register here is control state, so all of them are cleared, and a
    // pop pending at reset simply never reaches rdata_valid.
    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rlevel_q        <= '0;
            rdata_valid_q   <= 1'b0;
            rdata_id_q      <= '0;
            state_q         <= ST_ARB;
            rr_ptr_q        <= '0;
            owner_q         <= '0;
            burst_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values of the current cycle, independent of statement order.
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rlevel_q        <= level_d;
            rdata_valid_q   <= pop;
            if (pop) begin
                rdata_id_q <= sel;
            end
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            owner_q         <= owner_d;
            burst_cnt_q     <= burst_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt           = pop ? (NUM_REQ'(1) << sel) : '0;
    assign rd_en         = pop;
    assign raddr         = rbin_q[ptr_width-1:0];
    assign rdata_valid   = rdata_valid_q;
    assign rdata_id      = rdata_id_q;
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_arb_ctrl
//
// Self-checking bench for fifo_rd_arb_ctrl with a small FIFO (ptr_width=3,
// depth 8) so that pointer wrap and full depth are reached quickly.
// Expected pops (requester id, read address) are queued when stimulus is
// driven; a negedge monitor pops them as grants appear and then matches the
// rdata_valid/rdata_id beat one cycle later.
// -----------------------------------------------------------------------------
module tb_fifo_rd_arb_ctrl;

    localparam int PTR_W = 3;
    localparam int PW    = PTR_W + 1;
    localparam int NREQ  = 4;
    localparam int BLEN  = 4;
    localparam int AE    = 4;

    logic              rclk = 1'b0;
    logic              r_rst_n;
    logic [PW-1:0]     wptr_sync;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic              rd_en;
    logic [PTR_W-1:0]  raddr;
    logic              rdata_valid;
    logic [1:0]        rdata_id;
    logic [PW-1:0]     rptr;
    logic              rempty;
    logic              ralmost_empty;
    logic [PW-1:0]     rlevel;

    fifo_rd_arb_ctrl #(
        .ptr_width (PTR_W),
        .NUM_REQ   (NREQ),
        .BURST_LEN (BLEN),
        .AE_THRESH (AE)
    ) dut (
        .rclk          (rclk),
        .r_rst_n       (r_rst_n),
        .wptr_sync     (wptr_sync),
        .req           (req),
        .gnt           (gnt),
        .rd_en         (rd_en),
        .raddr         (raddr),
        .rdata_valid   (rdata_valid),
        .rdata_id      (rdata_id),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        int id;
        int addr;
    } pop_t;

    pop_t          exp_q[$];   // grants still to come
    int            vld_q[$];   // rdata_id beats still to come
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] tb_wbin;    // bench write pointer (binary)
    logic [PW-1:0] exp_rbin;   // read pointer after all queued pops
    logic [PW-1:0] prev_rptr = '0;
    pop_t          mon_e;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic advance_w(input int n);
        tb_wbin   = tb_wbin + PW'(n);
        wptr_sync = to_gray(tb_wbin);
    endtask

    task automatic expect_pop(input int id);
        exp_q.push_back('{id: id, addr: int'(exp_rbin[PTR_W-1:0])});
        exp_rbin = exp_rbin + 1'b1;
    endtask

    // Wait (bounded) until every queued grant and data beat has been seen.
    task automatic drain(input int max_cycles);
        int i = 0;
        while ((exp_q.size() != 0 || vld_q.size() != 0) && i < max_cycles) begin
            @(posedge rclk);
            #2;
            i++;
        end
        check("drain_pending", exp_q.size() + vld_q.size(), 0);
        exp_q.delete();
        vld_q.delete();
    endtask

    task automatic check_status(input string tag, input logic e_empty,
                                input int e_level, input logic e_ae);
        check({tag, "_rempty"}, rempty, e_empty);
        check({tag, "_rlevel"}, rlevel, e_level);
        check({tag, "_ae"},     ralmost_empty, e_ae);
        check({tag, "_rptr"},   rptr, to_gray(exp_rbin));
    endtask

    task automatic apply_reset();
        tick();
        r_rst_n   = 1'b0;
        req       = '0;
        tb_wbin   = '0;
        wptr_sync = '0;
        exp_rbin  = '0;
        repeat (2) tick();
        r_rst_n = 1'b1;
    endtask

    // One pop for requester id: request for one cycle, drop it the next.
    task automatic single_pop(input int id);
        tick();
        expect_pop(id);
        req = NREQ'(1) << id;
        tick();
        req = '0;
        tick();
        @(negedge rclk);
    endtask

    // Grant / data-beat monitor and Gray single-bit-step check.
    always @(negedge rclk) begin
        if (rd_en || gnt != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", gnt, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("gnt", gnt, 1 << mon_e.id);
                check("raddr", raddr, mon_e.addr);
                check("rd_en", rd_en, 1);
                vld_q.push_back(mon_e.id);
            end
        end
        if (rdata_valid) begin
            if (vld_q.size() == 0) begin
                check("unexpected_rdata_valid", rdata_valid, 0);
            end else begin
                check("rdata_id", rdata_id, vld_q.pop_front());
            end
        end
        if (r_rst_n === 1'b1 && rptr !== prev_rptr) begin
            check("rptr_gray_step", $countones(rptr ^ prev_rptr), 1);
        end
        prev_rptr = rptr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int sizes[3] = '{7, 8, 5};

    initial begin
        // ---- 1: reset with all requests high ----
        r_rst_n   = 1'b0;
        req       = '1;
        tb_wbin   = '0;
        wptr_sync = '0;
        exp_rbin  = '0;
        repeat (3) begin
            @(negedge rclk);
            check("rst_gnt", gnt, 0);
            check("rst_rd_en", rd_en, 0);
        end
        check_status("rst", 1'b1, 0, 1'b1);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata_id", rdata_id, 0);
        tick();
        r_rst_n = 1'b1;
        @(negedge rclk);
        check("post_rst_gnt", gnt, 0);
        check_status("post_rst", 1'b1, 0, 1'b1);
        tick();
        req = '0;

        // ---- 2: two entries, single requester ----
        tick();
        advance_w(1);
        @(negedge rclk);
        check("t2_empty_same_cycle", rempty, 1);
        tick();
        @(negedge rclk);
        check_status("t2_lvl1", 1'b0, 1, 1'b1);
        tick();
        advance_w(1);
        tick();
        @(negedge rclk);
        check_status("t2_lvl2", 1'b0, 2, 1'b1);
        tick();
        expect_pop(0);
        expect_pop(0);
        req = 4'b0001;
        drain(10);
        tick();
        req = '0;
        @(negedge rclk);
        check_status("t2_end", 1'b1, 0, 1'b1);
        check("t2_rptr_gray3", rptr, 3);

        // ---- 3: full depth, all requesting, bounded bursts ----
        apply_reset();
        advance_w(8);
        tick();
        @(negedge rclk);
        check_status("t3_full", 1'b0, 8, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) expect_pop(0);
        for (int k = 0; k < 4; k++) expect_pop(1);
        req = '1;
        drain(20);
        tick();
        req = '0;
        @(negedge rclk);
        check_status("t3_end", 1'b1, 0, 1'b1);

        // ---- 3b: lone requester bursts past BURST_LEN ----
        tick();
        advance_w(6);
        for (int k = 0; k < 6; k++) expect_pop(2);
        req = 4'b0100;
        drain(20);
        tick();
        req = '0;
        @(negedge rclk);
        check_status("t3b_end", 1'b1, 0, 1'b1);

        // ---- 4: almost-empty threshold (levels cross the pointer wrap) ----
        tick();
        advance_w(3);
        tick();
        @(negedge rclk);
        check_status("t4_lvl3", 1'b0, 3, 1'b1);
        tick();
        advance_w(1);
        tick();
        @(negedge rclk);
        check_status("t4_lvl4", 1'b0, 4, 1'b1);
        tick();
        advance_w(2);
        tick();
        @(negedge rclk);
        check_status("t4_lvl6", 1'b0, 6, 1'b0);
        single_pop(0);
        check_status("t4_lvl5", 1'b0, 5, 1'b0);
        single_pop(0);
        check_status("t4_lvl4_down", 1'b0, 4, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) expect_pop(0);
        req = 4'b0001;
        drain(20);
        tick();
        req = '0;
        @(negedge rclk);
        check_status("t4_end", 1'b1, 0, 1'b1);

        // ---- 5: repeated fill/drain through the pointer wrap ----
        for (int r = 0; r < 3; r++) begin
            tick();
            advance_w(sizes[r]);
            tick();
            @(negedge rclk);
            check_status($sformatf("t5_fill%0d", r), 1'b0, sizes[r], sizes[r] <= AE);
            tick();
            for (int k = 0; k < sizes[r]; k++) expect_pop(3);
            req = 4'b1000;
            drain(30);
            tick();
            req = '0;
            @(negedge rclk);
            check_status($sformatf("t5_drain%0d", r), 1'b1, 0, 1'b1);
        end

        // ---- 6: reset in the middle of a burst (owner 2, count 2) ----
        apply_reset();
        advance_w(7);
        single_pop(1);                // moves the round-robin pointer to 2
        tick();
        expect_pop(2);
        expect_pop(2);
        req = 4'b0100;                // ARB grant, then one BURST grant
        tick();
        tick();
        r_rst_n = 1'b0;
        @(negedge rclk);
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_rd_en", rd_en, 0);
        check("t6_last_beat", rdata_valid, 1);
        tick();
        @(negedge rclk);
        check("t6_no_beat", rdata_valid, 0);
        check("t6_gnt_in_rst", gnt, 0);
        check("t6_rempty", rempty, 1);
        check("t6_rlevel", rlevel, 0);
        check("t6_queues", exp_q.size() + vld_q.size(), 0);
        apply_reset();
        advance_w(4);
        tick();
        for (int k = 0; k < 4; k++) expect_pop(0);  // round-robin restarts at 0
        req = '1;
        drain(20);
        tick();
        req = '0;
        @(negedge rclk);
        check_status("t6_end", 1'b1, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
